// File: rtl/ddr_pkg.sv
// Shared definitions for the DDR serializer/deserializer paths: aligner state
// encoding, counter widths and the default link-training word.
package ddr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETTLE,
    CHECK,
    SLIP,
    LOCKED,
    FAIL
  } state_t;

  localparam int unsigned DATA_W       = 8;
  localparam int unsigned SLIP_CNT_W   = 3;
  localparam int unsigned MATCH_CNT_W  = 8;
  localparam int unsigned SETTLE_CNT_W = 4;

  // Non-periodic, so every bit rotation of it is a distinct word.
  localparam logic [DATA_W-1:0] TRAIN_PATTERN_DEFAULT = 8'h4B;

endpackage

// File: rtl/ddr_ides8_align.sv
// Word aligner for the 1:8 DDR deserializer: bit-slips the deserializer until
// the training word is seen LOCK_COUNT times in a row, then forwards words.
module ddr_ides8_align
  import ddr_pkg::*;
#(
  parameter logic [DATA_W-1:0] TRAIN_PATTERN = TRAIN_PATTERN_DEFAULT,
  parameter int unsigned       SETTLE_CYCLES = 4,
  parameter int unsigned       LOCK_COUNT    = 16,
  parameter int unsigned       MAX_SLIPS     = 7
) (
  input  logic              pclk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  input  logic              train_en,
  input  logic              retrain,
  output logic              calib,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic              locked,
  output logic              align_err
);

  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [MATCH_CNT_W-1:0]  MATCH_LAST  = MATCH_CNT_W'(LOCK_COUNT - 1);
  localparam logic [SLIP_CNT_W-1:0]   SLIP_LIMIT  = SLIP_CNT_W'(MAX_SLIPS);

  state_t                  state;
  logic [SLIP_CNT_W-1:0]   slip_cnt;
  logic [MATCH_CNT_W-1:0]  match_cnt;
  logic [SETTLE_CNT_W-1:0] settle_cnt;

  // Alignment FSM; flag outputs are set on the transition into their state.
  always_ff @(posedge pclk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      slip_cnt   <= '0;
      match_cnt  <= '0;
      settle_cnt <= '0;
      calib      <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
      locked     <= 1'b0;
      align_err  <= 1'b0;
    end else begin
      dout       <= din;
      dout_valid <= locked & ~train_en;
      calib      <= 1'b0;

      if (retrain) begin
        state      <= IDLE;
        slip_cnt   <= '0;
        match_cnt  <= '0;
        settle_cnt <= '0;
        locked     <= 1'b0;
        align_err  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (train_en) begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
              slip_cnt   <= '0;
            end
          end

          SETTLE: begin
            if (!train_en) begin
              state <= IDLE;
            end else if (settle_cnt == '0) begin
              state     <= CHECK;
              match_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt - SETTLE_CNT_W'(1);
            end
          end

          CHECK: begin
            if (!train_en) begin
              state <= IDLE;
            end else if (din == TRAIN_PATTERN) begin
              if (match_cnt == MATCH_LAST) begin
                state  <= LOCKED;
                locked <= 1'b1;
              end else begin
                match_cnt <= match_cnt + MATCH_CNT_W'(1);
              end
            end else if (slip_cnt < SLIP_LIMIT) begin
              state    <= SLIP;
              calib    <= 1'b1;
              slip_cnt <= slip_cnt + SLIP_CNT_W'(1);
            end else begin
              state     <= FAIL;
              align_err <= 1'b1;
            end
          end

          // The calib pulse for this cycle was already issued on entry.
          SLIP: begin
            if (!train_en) begin
              state <= IDLE;
            end else begin
              state      <= SETTLE;
              settle_cnt <= SETTLE_LOAD;
            end
          end

          LOCKED: begin
            state <= LOCKED;
          end

          FAIL: begin
            if (!train_en) begin
              state     <= IDLE;
              align_err <= 1'b0;
            end
          end

          default: begin
            state     <= IDLE;
            locked    <= 1'b0;
            align_err <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ddr_ides8_align.sv
// Self-checking bench for ddr_ides8_align with a behavioural bit-slip channel.
module tb_ddr_ides8_align;

  localparam logic [7:0] PAT    = 8'h4B;
  localparam int         S      = 4;
  localparam int         L      = 16;
  localparam int         M      = 7;
  localparam int         PERIOD = 2 + S;

  logic       pclk = 1'b0;
  logic       reset_n;
  logic [7:0] din;
  logic       train_en;
  logic       retrain;
  logic       calib;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic       align_err;

  int vectors     = 0;
  int miscompares = 0;

  int calib_edges[$];
  int lock_edge;
  int err_edge;

  always #5 pclk = ~pclk;

  ddr_ides8_align #(
    .TRAIN_PATTERN(PAT),
    .SETTLE_CYCLES(S),
    .LOCK_COUNT   (L),
    .MAX_SLIPS    (M)
  ) dut (
    .pclk      (pclk),
    .reset_n   (reset_n),
    .din       (din),
    .train_en  (train_en),
    .retrain   (retrain),
    .calib     (calib),
    .dout      (dout),
    .dout_valid(dout_valid),
    .locked    (locked),
    .align_err (align_err)
  );

  // Expected timing, counted in edges after E0.
  function automatic int exp_calib(input int i);
    return S + 1 + PERIOD * i;
  endfunction

  function automatic int exp_lock(input int k);
    return S + L + PERIOD * k;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] x, input int r);
    logic [7:0] y;
    y = x;
    for (int i = 0; i < r; i++) y = {y[6:0], y[7]};
    return y;
  endfunction

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic go_idle();
    train_en = 1'b0;
    retrain  = 1'b1;
    step();
    retrain = 1'b0;
    step();
  endtask

  // Channel model: word arrives rotated by rot bits; each calib pulse removes
  // one bit of rotation (when rot_en). Records calib/lock/fail edge indices.
  task automatic run_train(input int k, input bit rot_en, input int glitch,
                           input bit use_junk, input logic [7:0] junk,
                           input int budget);
    int rot;
    rot = k;
    calib_edges.delete();
    lock_edge = -1;
    err_edge  = -1;
    train_en  = 1'b1;
    din       = use_junk ? junk : rotl(PAT, rot);
    for (int n = 0; n < budget; n++) begin
      step();
      if (calib === 1'b1) begin
        calib_edges.push_back(n);
        if (rot_en) rot = (rot + 7) % 8;
      end
      if (locked === 1'b1 && lock_edge < 0) lock_edge = n;
      if (align_err === 1'b1 && err_edge < 0) err_edge = n;
      if (lock_edge >= 0 || err_edge >= 0) break;
      if (use_junk)         din = junk;
      else if (n + 1 == glitch) din = 8'h00;
      else                  din = rotl(PAT, rot);
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b1;
    din      = 8'h00;
    train_en = 1'b0;
    retrain  = 1'b0;
    #2 reset_n = 1'b0;
    din = 8'hA5;
    step();
    step();
    vectors++;
    if ({calib, dout, dout_valid, locked, align_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_outputs got %h want 000", {calib, dout, dout_valid, locked, align_err});
    end
    @(negedge pclk);
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_dout_latency();
    logic [7:0] prev;
    train_en = 1'b0;
    for (int i = 0; i < 12; i++) begin
      prev = 8'($urandom);
      din  = prev;
      step();
      vectors++;
      if (dout !== prev || dout_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL dout_latency got %h/%b want %h/0", dout, dout_valid, prev);
      end
    end
  endtask

  task automatic test_aligned();
    go_idle();
    run_train(0, 1'b1, -1, 1'b0, 8'h00, 60);
    vectors++;
    if (calib_edges.size() != 0) begin
      miscompares++;
      $display("FAIL aligned_calib_count got %0d want 0", calib_edges.size());
    end
    vectors++;
    if (lock_edge != exp_lock(0)) begin
      miscompares++;
      $display("FAIL aligned_lock_edge got %0d want %0d", lock_edge, exp_lock(0));
    end
    step();
    vectors++;
    if (dout_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL valid_while_training got %b want 0", dout_valid);
    end
    train_en = 1'b0;
    step();
    vectors++;
    if (dout_valid !== 1'b1 || locked !== 1'b1) begin
      miscompares++;
      $display("FAIL valid_after_train_drop got %b/%b want 1/1", dout_valid, locked);
    end
    din = 8'h3C;
    step();
    step();
    vectors++;
    if (locked !== 1'b1 || dout !== 8'h3C) begin
      miscompares++;
      $display("FAIL lock_holds got %b/%h want 1/3c", locked, dout);
    end
  endtask

  task automatic test_rotated();
    int ks[3];
    ks[0] = 3;
    ks[1] = int'($urandom_range(7, 1));
    ks[2] = int'($urandom_range(7, 0));
    foreach (ks[j]) begin
      go_idle();
      run_train(ks[j], 1'b1, -1, 1'b0, 8'h00, 120);
      vectors++;
      if (calib_edges.size() != ks[j]) begin
        miscompares++;
        $display("FAIL rot%0d_calib_count got %0d want %0d", ks[j], calib_edges.size(), ks[j]);
      end
      foreach (calib_edges[i]) begin
        vectors++;
        if (calib_edges[i] != exp_calib(i)) begin
          miscompares++;
          $display("FAIL rot%0d_calib_edge%0d got %0d want %0d", ks[j], i, calib_edges[i], exp_calib(i));
        end
      end
      vectors++;
      if (lock_edge != exp_lock(ks[j])) begin
        miscompares++;
        $display("FAIL rot%0d_lock_edge got %0d want %0d", ks[j], lock_edge, exp_lock(ks[j]));
      end
    end
  endtask

  task automatic test_garbage();
    logic [7:0] junk;
    bit         is_rot;
    junk = 8'hFF;
    for (int t = 0; t < 4; t++) begin
      junk   = 8'($urandom);
      is_rot = 1'b0;
      for (int r = 0; r < 8; r++) if (rotl(PAT, r) == junk) is_rot = 1'b1;
      if (!is_rot) break;
      junk = 8'hFF;
    end
    go_idle();
    run_train(0, 1'b1, -1, 1'b1, junk, 100);
    vectors++;
    if (calib_edges.size() != M) begin
      miscompares++;
      $display("FAIL garbage_calib_count got %0d want %0d", calib_edges.size(), M);
    end
    foreach (calib_edges[i]) begin
      vectors++;
      if (calib_edges[i] != exp_calib(i)) begin
        miscompares++;
        $display("FAIL garbage_calib_edge%0d got %0d want %0d", i, calib_edges[i], exp_calib(i));
      end
    end
    vectors++;
    if (err_edge != exp_calib(M) || locked !== 1'b0) begin
      miscompares++;
      $display("FAIL garbage_err_edge got %0d/%b want %0d/0", err_edge, locked, exp_calib(M));
    end
    train_en = 1'b0;
    step();
    vectors++;
    if (align_err !== 1'b0) begin
      miscompares++;
      $display("FAIL garbage_err_clear got %b want 0", align_err);
    end
  endtask

  task automatic test_partial_lock();
    int g;
    g = S + 1 + 10;
    go_idle();
    run_train(0, 1'b0, g, 1'b0, 8'h00, 80);
    vectors++;
    if (calib_edges.size() != 1 || (calib_edges.size() == 1 && calib_edges[0] != g)) begin
      miscompares++;
      $display("FAIL partial_calib got count %0d want one at edge %0d", calib_edges.size(), g);
    end
    vectors++;
    if (lock_edge != g + PERIOD + L - 1) begin
      miscompares++;
      $display("FAIL partial_lock_edge got %0d want %0d", lock_edge, g + PERIOD + L - 1);
    end
  endtask

  task automatic test_abort();
    bit seen;
    go_idle();
    din      = PAT;
    train_en = 1'b1;
    step();
    step();
    train_en = 1'b0;
    seen     = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (calib === 1'b1 || locked === 1'b1) seen = 1'b1;
    end
    vectors++;
    if (seen) begin
      miscompares++;
      $display("FAIL abort_settle got activity=1 want 0");
    end
    run_train(1, 1'b1, -1, 1'b0, 8'h00, 6);
    train_en = 1'b0;
    step();
    vectors++;
    if (calib_edges.size() != 1 || calib !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_slip got pulses %0d calib %b want 1/0", calib_edges.size(), calib);
    end
    step();
    run_train(0, 1'b1, -1, 1'b0, 8'h00, 60);
    vectors++;
    if (lock_edge != exp_lock(0) || calib_edges.size() != 0) begin
      miscompares++;
      $display("FAIL abort_restart got lock %0d want %0d", lock_edge, exp_lock(0));
    end
  endtask

  task automatic test_retrain();
    go_idle();
    run_train(0, 1'b1, -1, 1'b0, 8'h00, 60);
    retrain = 1'b1;
    step();
    retrain = 1'b0;
    vectors++;
    if (locked !== 1'b0) begin
      miscompares++;
      $display("FAIL retrain_unlock got %b want 0", locked);
    end
    run_train(2, 1'b1, -1, 1'b0, 8'h00, 80);
    vectors++;
    if (lock_edge != exp_lock(2) || calib_edges.size() != 2) begin
      miscompares++;
      $display("FAIL retrain_relock got %0d/%0d want %0d/2", lock_edge, calib_edges.size(), exp_lock(2));
    end
  endtask

  task automatic test_reset_mid_slip();
    go_idle();
    run_train(3, 1'b1, -1, 1'b0, 8'h00, S + 2);
    vectors++;
    if (calib !== 1'b1) begin
      miscompares++;
      $display("FAIL slip_before_reset got %b want 1", calib);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if ({calib, dout, dout_valid, locked, align_err} !== 12'h000) begin
      miscompares++;
      $display("FAIL reset_mid_slip got %h want 000", {calib, dout, dout_valid, locked, align_err});
    end
    train_en = 1'b0;
    step();
    @(negedge pclk);
    reset_n = 1'b1;
    step();
    run_train(0, 1'b1, -1, 1'b0, 8'h00, 60);
    vectors++;
    if (lock_edge != exp_lock(0) || calib_edges.size() != 0) begin
      miscompares++;
      $display("FAIL reset_restart got lock %0d want %0d", lock_edge, exp_lock(0));
    end
  endtask

  initial begin
    test_reset();
    test_dout_latency();
    test_aligned();
    test_rotated();
    test_garbage();
    test_partial_lock();
    test_abort();
    test_retrain();
    test_reset_mid_slip();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
